// File: rtl/clkena_gen.sv
// clkena_gen: multi-channel fractional clock-enable generator gated by a PLL lock/settle sequencer.
//   refclk      - sole clock, all state on its rising edge
//   rst_n       - asynchronous active-low reset
//   pll_locked  - raw PLL lock flag, synchronised internally
//   cfg_inc     - per-channel accumulator increment, channel i at [i*ACC_W +: ACC_W]
//   cfg_phase   - per-channel starting accumulator value, same packing
//   cfg_load    - one-cycle strobe capturing cfg_inc/cfg_phase; realigns all channels in RUN
//   ce          - per-channel one-cycle enable on accumulator wrap
//   ce_n        - per-channel one-cycle enable on accumulator MSB rising without wrap
//   locked      - high only while enables are running
module clkena_gen #(
    parameter int CHANNELS      = 5,
    parameter int ACC_W         = 24,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic                      refclk,
    input  logic                      rst_n,
    input  logic                      pll_locked,
    input  logic [CHANNELS*ACC_W-1:0] cfg_inc,
    input  logic [CHANNELS*ACC_W-1:0] cfg_phase,
    input  logic                      cfg_load,
    output logic [CHANNELS-1:0]       ce,
    output logic [CHANNELS-1:0]       ce_n,
    output logic                      locked
);
    localparam int CNT_W = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ACC_W-1:0] HALF = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

    state_t               state_q, state_d;
    logic                 lk_meta_q, lk_s_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHANNELS-1:0]  ce_q, ce_d, ce_n_q, ce_n_d;
    logic                 run_step;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta_q <= 1'b0;
            lk_s_q    <= 1'b0;
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            ce_q      <= '0;
            ce_n_q    <= '0;
        end else begin
            lk_meta_q <= pll_locked;
            lk_s_q    <= lk_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ce_q      <= ce_d;
            ce_n_q    <= ce_n_d;
        end
    end

    // Counter is only nonzero while settling; any exit from SETTLE clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            WAIT_LOCK: state_d = lk_s_q ? SETTLE : WAIT_LOCK;
            SETTLE: begin
                if (!lk_s_q)
                    state_d = WAIT_LOCK;
                else if (cnt_q == CNT_LAST)
                    state_d = RUN;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            RUN:     state_d = lk_s_q ? RUN : WAIT_LOCK;
            default: state_d = WAIT_LOCK;
        endcase
    end

    // Accumulate only in a RUN cycle that is neither a realign nor a lock-loss edge;
    // every other cycle reloads the phase and suppresses pulses.
    assign run_step = (state_q == RUN) && lk_s_q && !cfg_load;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [ACC_W-1:0] inc_sh_q, ph_sh_q, acc_q, acc_d, inc_eff, ph_new;
        logic [ACC_W:0]   sum;

        // Clamping to half scale caps the rate at refclk/2 and keeps ce_n well defined.
        assign inc_eff = (inc_sh_q > HALF) ? HALF : inc_sh_q;
        assign sum     = {1'b0, acc_q} + {1'b0, inc_eff};
        // A load on this edge means the port phase is the shadow's next value.
        assign ph_new  = cfg_load ? cfg_phase[g*ACC_W +: ACC_W] : ph_sh_q;
        assign acc_d   = run_step ? sum[ACC_W-1:0] : ph_new;
        assign ce_d[g]   = run_step & sum[ACC_W];
        assign ce_n_d[g] = run_step & ~acc_q[ACC_W-1] & sum[ACC_W-1] & ~sum[ACC_W];

        always_ff @(posedge refclk or negedge rst_n) begin
            if (!rst_n) begin
                inc_sh_q <= '0;
                ph_sh_q  <= '0;
                acc_q    <= '0;
            end else begin
                if (cfg_load) begin
                    inc_sh_q <= cfg_inc[g*ACC_W +: ACC_W];
                    ph_sh_q  <= cfg_phase[g*ACC_W +: ACC_W];
                end
                acc_q <= acc_d;
            end
        end
    end

    assign ce     = ce_q;
    assign ce_n   = ce_n_q;
    assign locked = (state_q == RUN);
endmodule

// File: tb/tb_clkena_gen.sv
// tb_clkena_gen: directed self-checking bench for clkena_gen (3 channels, 24-bit, 16-cycle settle).
module tb_clkena_gen;
    localparam int CH = 3;
    localparam int W  = 24;
    localparam int SC = 16;

    logic            refclk = 1'b0;
    logic            rst_n = 1'b0;
    logic            pll_locked = 1'b0;
    logic            cfg_load = 1'b0;
    logic [CH*W-1:0] cfg_inc = '0;
    logic [CH*W-1:0] cfg_phase = '0;
    logic [CH-1:0]   ce, ce_n;
    logic            locked;

    int errs = 0;
    int checks = 0;

    clkena_gen #(.CHANNELS(CH), .ACC_W(W), .SETTLE_CYCLES(SC)) dut (
        .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked),
        .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .cfg_load(cfg_load),
        .ce(ce), .ce_n(ce_n), .locked(locked)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] i0, p0, i1, p1, i2, p2);
        cfg_inc   = {i2, i1, i0};
        cfg_phase = {p2, p1, p0};
        cfg_load  = 1'b1;
        step();
        cfg_load  = 1'b0;
    endtask

    task automatic wait_lock(output int n, output int bad);
        n = 0;
        bad = 0;
        while (!locked && n < 40) begin
            step();
            n++;
            if ((ce | ce_n) != '0) bad++;
        end
    endtask

    initial begin
        int n, bad, c0, c1, cn0, gaps, last;
        int n_ce0, n_cen0, n_ce1, n_cen1, n_ch2;

        step();
        step();
        check("rst_ce", ce, 0);
        check("rst_ce_n", ce_n, 0);
        check("rst_locked", locked, 0);

        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            step();
            if (locked || (ce | ce_n) != '0) bad++;
        end
        check("idle_quiet", bad, 0);

        pll_locked = 1'b1;
        repeat (10) step();
        check("mid_settle_locked", locked, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ce", ce, 0);
        bad = 0;
        repeat (30) begin
            step();
            if (locked || (ce | ce_n) != '0) bad++;
        end
        check("held_in_reset", bad, 0);
        rst_n = 1'b1;
        wait_lock(n, bad);
        check("lock_latency_after_rst", n, 19);
        check("no_ce_before_lock", bad, 0);

        bad = 0;
        repeat (50) begin
            step();
            if ((ce | ce_n) != '0) bad++;
        end
        check("zero_shadow_quiet", bad, 0);

        load(24'h400000, 24'h0, 24'h400000, 24'h800000, 24'h0, 24'h0);
        pll_locked = 1'b0;
        n = 0;
        while (locked && n < 6) begin
            step();
            n++;
        end
        check("unlock_latency", n, 3);
        repeat (10) step();
        pll_locked = 1'b1;
        wait_lock(n, bad);
        check("lock_latency", n, 19);
        check("no_ce_during_settle", bad, 0);
        check("run0_ce", ce, 0);

        n_ce0 = 0; n_cen0 = 0; n_ce1 = 0; n_cen1 = 0; n_ch2 = 0;
        c0 = -1; c1 = -1; cn0 = -1;
        for (int c = 1; c <= 1000; c++) begin
            step();
            if (ce[0]) begin n_ce0++; if (c0 < 0) c0 = c; end
            if (ce_n[0]) begin n_cen0++; if (cn0 < 0) cn0 = c; end
            if (ce[1]) begin n_ce1++; if (c1 < 0) c1 = c; end
            if (ce_n[1]) n_cen1++;
            if (ce[2] || ce_n[2]) n_ch2++;
        end
        check("rate_ce0_count", n_ce0, 250);
        check("rate_cen0_count", n_cen0, 250);
        check("rate_ce1_count", n_ce1, 250);
        check("rate_cen1_count", n_cen1, 250);
        check("zero_inc_ch2", n_ch2, 0);
        check("first_ce0", c0, 4);
        check("first_cen0", cn0, 2);
        check("first_ce1", c1, 2);

        step();
        load(24'h400000, 24'h0, 24'h400000, 24'h800000, 24'h0, 24'h0);
        check("realign_ce_zero", ce, 0);
        check("realign_cen_zero", ce_n, 0);
        c0 = -1; c1 = -1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (ce[0] && c0 < 0) c0 = k;
            if (ce[1] && c1 < 0) c1 = k;
        end
        check("realign_first_ce0", c0, 4);
        check("realign_first_ce1", c1, 2);

        pll_locked = 1'b0;
        n = 0;
        while (locked && n < 6) begin
            step();
            n++;
        end
        check("run_unlock_latency", n, 3);
        check("unlock_edge_ce", ce | ce_n, 0);
        bad = 0;
        repeat (10) begin
            step();
            if (locked || (ce | ce_n) != '0) bad++;
        end
        check("unlocked_quiet", bad, 0);
        pll_locked = 1'b1;
        wait_lock(n, bad);
        check("relock_latency", n, 19);
        check("relock_no_early_ce", bad, 0);
        c0 = -1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (ce[0] && c0 < 0) c0 = k;
        end
        check("relock_first_ce0", c0, 4);

        load(24'hFFFFFF, 24'h0, 24'd1129779, 24'h0, 24'h0, 24'h0);
        check("frac_load_ce_zero", ce, 0);
        n_ce0 = 0; n_cen0 = 0; n_ce1 = 0; n_cen1 = 0; n_ch2 = 0;
        gaps = 0; last = -1; bad = 0;
        for (int k = 1; k <= 14850; k++) begin
            step();
            if (!locked) bad++;
            if (ce[0]) n_ce0++;
            if (ce_n[0]) n_cen0++;
            if (ce_n[1]) n_cen1++;
            if (ce[2] || ce_n[2]) n_ch2++;
            if (ce[1]) begin
                n_ce1++;
                if (last >= 0 && (k - last) != 14 && (k - last) != 15) gaps++;
                last = k;
            end
        end
        check("clamp_ce0_count", n_ce0, 7425);
        check("clamp_cen0_count", n_cen0, 7425);
        check("frac_ce1_count", n_ce1, 1000);
        check("frac_cen1_count", n_cen1, 1000);
        check("frac_bad_gaps", gaps, 0);
        check("frac_zero_ch2", n_ch2, 0);
        check("frac_stayed_locked", bad, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
